// File: rtl/aes_tx_framer_if.sv
// aes_tx_framer_if: register slave, ciphertext sink and TX stream source of the framer
interface aes_tx_framer_if #(
    parameter int AES_DATA_WIDTH   = 128,
    parameter int MAC_STREAM_WIDTH = 32
);
    logic [31:0]                 avs_address;
    logic                        avs_write;
    logic [31:0]                 avs_writedata;
    logic                        avs_read;
    logic [31:0]                 avs_readdata;
    logic                        aes_valid;
    logic [AES_DATA_WIDTH-1:0]   aes_data;
    logic                        aes_last;
    logic                        aes_ready;
    logic [MAC_STREAM_WIDTH-1:0] tx_data;
    logic                        tx_valid;
    logic                        tx_ready;
    logic                        tx_sop;
    logic                        tx_eop;
    logic [1:0]                  tx_empty;

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read, aes_valid, aes_data, aes_last, tx_ready,
        output avs_readdata, aes_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_empty
    );
    modport master (
        output avs_address, avs_write, avs_writedata, avs_read, aes_valid, aes_data, aes_last, tx_ready,
        input  avs_readdata, aes_ready, tx_data, tx_valid, tx_sop, tx_eop, tx_empty
    );
endinterface

// File: rtl/aes_tx_framer.sv
// aes_tx_framer: wraps AES ciphertext blocks into Ethernet frames for the TSE MAC TX stream
module aes_tx_framer #(
    parameter int          AES_DATA_WIDTH    = 128,
    parameter int          MAC_STREAM_WIDTH  = 32,
    parameter int          WORD_COUNTER_SIZE = 8,
    parameter int          MAX_BLOCKS        = 64,
    parameter logic [15:0] ETHERTYPE         = 16'h88B5
) (
    input logic            clk,
    input logic            rst_n,
    aes_tx_framer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;
    localparam logic [WORD_COUNTER_SIZE-1:0] MAX_CNT = WORD_COUNTER_SIZE'(MAX_BLOCKS);
    localparam logic [WORD_COUNTER_SIZE-1:0] MIN_CNT = WORD_COUNTER_SIZE'(3);

    state_t                       state, next;
    logic [47:0]                  src_mac, dst_mac, src_sh, dst_sh;
    logic [15:0]                  frame_seq;
    logic [WORD_COUNTER_SIZE-1:0] blk_cnt;
    logic [1:0]                   beat;
    logic [4:0]                   wcnt;
    logic [AES_DATA_WIDTH-1:0]    buffer;
    logic                         buf_full, end_f;
    logic [31:0]                  readdata, rd_mux;
    logic [MAC_STREAM_WIDTH-1:0]  hdr_word, tx_data;
    logic                         tx_valid, tx_sop, tx_eop, aes_ready, accept, load, last_word;

    assign accept    = tx_valid && bus.tx_ready;
    assign load      = bus.aes_valid && aes_ready;
    assign last_word = buf_full && end_f && beat == 2'd3;
    assign hdr_word  = beat == 2'd0 ? dst_sh[47:16] :
                       beat == 2'd1 ? {dst_sh[15:0], src_sh[47:32]} :
                       beat == 2'd2 ? src_sh[31:0] : {ETHERTYPE, frame_seq};
    assign rd_mux    = bus.avs_address == 32'h1000 ? {16'h0, src_mac[47:32]} :
                       bus.avs_address == 32'h1004 ? src_mac[31:0] :
                       bus.avs_address == 32'h1008 ? {16'h0, dst_mac[47:32]} :
                       bus.avs_address == 32'h100C ? dst_mac[31:0] :
                       bus.avs_address == 32'h1010 ? {15'h0, state != IDLE, frame_seq} : 32'h0;

    assign bus.avs_readdata = readdata;
    assign bus.aes_ready    = aes_ready;
    assign bus.tx_data      = tx_data;
    assign bus.tx_valid     = tx_valid;
    assign bus.tx_sop       = tx_sop;
    assign bus.tx_eop       = tx_eop;
    assign bus.tx_empty     = 2'b00;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    always_comb begin
        next      = state;
        tx_valid  = 1'b0;
        tx_sop    = 1'b0;
        tx_eop    = 1'b0;
        tx_data   = '0;
        aes_ready = 1'b0;
        case (state)
            IDLE: next = bus.aes_valid ? HDR : IDLE;
            HDR: begin
                tx_valid = 1'b1;
                tx_sop   = beat == 2'd0;
                tx_data  = hdr_word;
                next     = accept && beat == 2'd3 ? PAYLOAD : HDR;
            end
            PAYLOAD: begin
                aes_ready = !buf_full;
                tx_valid  = buf_full;
                tx_data   = buffer[AES_DATA_WIDTH-1 -: MAC_STREAM_WIDTH];
                tx_eop    = last_word && blk_cnt >= MIN_CNT;
                next      = accept && last_word ? (blk_cnt < MIN_CNT ? PAD : IDLE) : PAYLOAD;
            end
            default: begin
                tx_valid = 1'b1;
                tx_eop   = wcnt == 5'd15;
                next     = accept && tx_eop ? IDLE : PAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_mac   <= '0;
            dst_mac   <= '0;
            src_sh    <= '0;
            dst_sh    <= '0;
            frame_seq <= '0;
            blk_cnt   <= '0;
            beat      <= '0;
            wcnt      <= '0;
            buffer    <= '0;
            buf_full  <= 1'b0;
            end_f     <= 1'b0;
            readdata  <= '0;
        end else begin
            if (bus.avs_write) begin
                if (bus.avs_address == 32'h1000) src_mac[47:32] <= bus.avs_writedata[15:0];
                if (bus.avs_address == 32'h1004) src_mac[31:0]  <= bus.avs_writedata;
                if (bus.avs_address == 32'h1008) dst_mac[47:32] <= bus.avs_writedata[15:0];
                if (bus.avs_address == 32'h100C) dst_mac[31:0]  <= bus.avs_writedata;
            end
            readdata <= bus.avs_read ? rd_mux : 32'h0;
            // addresses are frozen per frame so mid-frame writes land on the next one
            if (state == IDLE && bus.aes_valid) begin
                src_sh  <= src_mac;
                dst_sh  <= dst_mac;
                blk_cnt <= '0;
                beat    <= '0;
                wcnt    <= '0;
                end_f   <= 1'b0;
            end
            if (load) begin
                buffer   <= bus.aes_data;
                buf_full <= 1'b1;
                blk_cnt  <= blk_cnt + 1'b1;
                end_f    <= bus.aes_last || blk_cnt + 1'b1 == MAX_CNT;
            end
            if (accept) begin
                beat <= beat + 1'b1;
                wcnt <= wcnt == 5'd16 ? wcnt : wcnt + 1'b1;
                if (state == PAYLOAD) buffer <= buffer << MAC_STREAM_WIDTH;
                if (state == PAYLOAD && beat == 2'd3) buf_full <= 1'b0;
                if (tx_eop) frame_seq <= frame_seq + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_tx_framer.sv
// tb_aes_tx_framer: directed frame tests of aes_tx_framer with MAX_BLOCKS=4
module tb_aes_tx_framer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int nw = 0;
    logic [31:0] rd [64];
    bit rs [64];
    bit re [64];
    logic [127:0] blks [8];
    logic [31:0] v;

    aes_tx_framer_if bus ();
    aes_tx_framer #(.MAX_BLOCKS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] pw(input int k, input int j);
        return {8'hA0, 8'(k), 8'(j), 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic avs_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_write = 1'b1; bus.avs_address = a; bus.avs_writedata = d;
        @(negedge clk);
        bus.avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_read = 1'b1; bus.avs_address = a;
        @(negedge clk);
        bus.avs_read = 1'b0;
        d = bus.avs_readdata;
    endtask

    task automatic set_macs();
        avs_wr(32'h1000, 32'h0000_6677);
        avs_wr(32'h1004, 32'h8899_AABB);
        avs_wr(32'h1008, 32'h0000_0011);
        avs_wr(32'h100C, 32'h2233_4455);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // offers nblk blocks and records accepted TX words until goal words are seen
    task automatic pump(input int nblk, input int goal, input int stall_at, input int wr_cyc, input logic [31:0] wr_dat);
        int bi = 0;
        int cyc = 0;
        int stall = 0;
        bit did = 0;
        logic [31:0] held = '0;
        nw = 0;
        while (nw < goal && cyc < 400) begin
            @(negedge clk);
            bus.aes_valid = bi < nblk;
            bus.aes_data = blks[bi < nblk ? bi : 0];
            bus.aes_last = bi == nblk - 1;
            bus.avs_write = cyc == wr_cyc;
            bus.avs_address = 32'h1008;
            bus.avs_writedata = wr_dat;
            if (nw == stall_at && !did && bus.tx_valid) begin
                did = 1; stall = 5; held = bus.tx_data;
            end
            bus.tx_ready = stall == 0;
            if (stall > 0) begin
                if (stall < 5) chk("stall_hold", bus.tx_data, held);
                stall--;
            end else if (bus.tx_valid && nw < 64) begin
                rd[nw] = bus.tx_data; rs[nw] = bus.tx_sop; re[nw] = bus.tx_eop;
                nw++;
            end
            if (bus.aes_valid && bus.aes_ready) bi++;
            cyc++;
        end
        if (nw < goal) chk("pump_timeout", nw, goal);
        @(negedge clk);
        bus.aes_valid = 1'b0; bus.tx_ready = 1'b0; bus.avs_write = 1'b0;
    endtask

    task automatic check_frame(input int b, input int nb, input int ko, input logic [15:0] seq, input logic [31:0] w0);
        int len = nb >= 3 ? 4 + 4 * nb : 16;
        int neop = 0;
        int nsop = 0;
        chk("hdr_w0", rd[b], w0);
        chk("hdr_w3", rd[b+3], {16'h88B5, seq});
        for (int i = 0; i < nb * 4; i++) chk("payload", rd[b+4+i], pw(ko + i / 4, i % 4));
        for (int i = 4 + 4 * nb; i < len; i++) chk("pad_zero", rd[b+i], 32'h0);
        for (int i = b; i < b + len; i++) begin
            neop += int'(re[i]);
            nsop += int'(rs[i]);
        end
        chk("sop_first", 32'(rs[b]), 32'h1);
        chk("sop_count", nsop, 32'h1);
        chk("eop_last", 32'(re[b+len-1]), 32'h1);
        chk("eop_count", neop, 32'h1);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) blks[k] = {pw(k, 0), pw(k, 1), pw(k, 2), pw(k, 3)};
        bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
        bus.aes_valid = 1'b0; bus.aes_data = '0; bus.aes_last = 1'b0; bus.tx_ready = 1'b0;

        do_reset();
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_aes_ready", 32'(bus.aes_ready), 32'h0);
        chk("rst_tx_empty", 32'(bus.tx_empty), 32'h0);
        chk("rst_readdata", bus.avs_readdata, 32'h0);
        avs_rd(32'h1010, v); chk("rst_status", v, 32'h0);

        // single block: 8 data-bearing words then 8 pad words
        set_macs();
        avs_rd(32'h1000, v); chk("rd_src_hi", v, 32'h0000_6677);
        avs_rd(32'h100C, v); chk("rd_dst_lo", v, 32'h2233_4455);
        avs_wr(32'h1014, 32'hFFFF_FFFF);
        avs_rd(32'h1014, v); chk("rd_unmapped", v, 32'h0);
        avs_wr(32'h1010, 32'hFFFF_FFFF);
        avs_rd(32'h1010, v); chk("status_ro", v, 32'h0);
        pump(1, 16, -1, -1, 32'h0);
        chk("one_blk_w4", rd[4], 32'hA000_005A);
        chk("one_blk_w7", rd[7], 32'hA000_035A);
        check_frame(0, 1, 0, 16'h0000, 32'h0011_2233);
        avs_rd(32'h1010, v); chk("status_after", v, 32'h0000_0001);

        // three blocks fill the minimum frame exactly
        do_reset();
        set_macs();
        pump(3, 16, -1, -1, 32'h0);
        chk("hdr_w1", rd[1], 32'h4455_6677);
        chk("hdr_w2", rd[2], 32'h8899_AABB);
        chk("w15_eop_data", rd[15], 32'hA002_035A);
        check_frame(0, 3, 0, 16'h0000, 32'h0011_2233);

        // back-pressure mid-payload
        pump(3, 16, 6, -1, 32'h0);
        check_frame(0, 3, 0, 16'h0001, 32'h0011_2233);

        // DST write during payload only affects the following frame
        pump(2, 16, -1, 7, 32'h0000_CAFE);
        check_frame(0, 2, 0, 16'h0002, 32'h0011_2233);
        pump(1, 16, -1, -1, 32'h0);
        check_frame(0, 1, 0, 16'h0003, 32'hCAFE_2233);

        // truncation at MAX_BLOCKS=4 splits six blocks into two frames
        do_reset();
        set_macs();
        pump(6, 36, -1, -1, 32'h0);
        check_frame(0, 4, 0, 16'h0000, 32'h0011_2233);
        check_frame(20, 2, 4, 16'h0001, 32'h0011_2233);
        avs_rd(32'h1010, v); chk("status_trunc", v, 32'h0000_0002);

        // reset during header word 2 abandons the frame
        pump(1, 2, -1, -1, 32'h0);
        chk("pre_rst_w2", bus.tx_data, 32'h8899_AABB);
        chk("pre_rst_valid", 32'(bus.tx_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("arst_tx_data", bus.tx_data, 32'h0);
        chk("arst_tx_eop", 32'(bus.tx_eop), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_macs();
        pump(1, 16, -1, -1, 32'h0);
        check_frame(0, 1, 0, 16'h0000, 32'h0011_2233);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
